// File: rtl/ram_p2cc_if.sv
// Host-side bus of the 128->512 upsizing block FIFO: word input, block pop and status.
interface ram_p2cc_if #(parameter int D_WIDTH = 128);
  logic                   i_en_w;
  logic [D_WIDTH-1:0]     i_data;
  logic                   i_last;
  logic                   i_en_r;
  logic [4*D_WIDTH-1:0]   o_data;
  logic [2:0]             o_words;
  logic                   o_sig;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_err;

  modport slave  (input  i_en_w, i_data, i_last, i_en_r,
                  output o_data, o_words, o_sig, o_full, o_empty, o_err);
  modport master (output i_en_w, i_data, i_last, i_en_r,
                  input  o_data, o_words, o_sig, o_full, o_empty, o_err);
endinterface

// File: rtl/ram_p2cc.sv
// Packs 128-bit host words into 512-bit blocks (zero-padded short tail) queued in a block FIFO.
// Optional sticky overflow/underflow flag on o_err when RAM_P2CC_ERR_EN is defined.
module ram_p2cc #(
  parameter int A_WIDTH = 3,
  parameter int D_WIDTH = 128
) (
  input  logic       i_clk,
  input  logic       i_rst,
  ram_p2cc_if.slave  bus
);
  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH:0] FULL_CNT = (A_WIDTH+1)'(DEPTH);

  typedef logic [3:0][D_WIDTH-1:0] blk_t;
  typedef struct packed {
    logic [2:0] words;
    blk_t       data;
  } entry_t;

  blk_t             asm_q, asm_d;
  logic [2:0]       fill_q, fill_d;
  logic             cmt_vld_q, cmt_vld_d;
  entry_t           cmt_q, cmt_d;
  logic [A_WIDTH:0] wptr_q, wptr_d, rptr_q, rptr_d;
  entry_t           rd_q, rd_d;
  logic             sig_q, sig_d;
  entry_t           mem_q [DEPTH];

  logic [A_WIDTH:0] occ, occ_tot;
  logic             full, empty, acc, flush, done, pop;

  // The pending commit reserves its slot so a completing block can never overflow.
  assign occ     = wptr_q - rptr_q;
  assign occ_tot = occ + {{A_WIDTH{1'b0}}, cmt_vld_q};
  assign full    = (occ_tot == FULL_CNT);
  assign empty   = (occ == '0);
  assign acc     = bus.i_en_w && !full;
  assign flush   = !bus.i_en_w && bus.i_last && (fill_q != 3'd0) && !full;
  assign done    = (acc && ((fill_q == 3'd3) || bus.i_last)) || flush;
  assign pop     = bus.i_en_r && !empty;

  always_comb begin
    asm_d     = asm_q;
    fill_d    = fill_q;
    cmt_vld_d = done;
    cmt_d     = cmt_q;
    wptr_d    = wptr_q + {{A_WIDTH{1'b0}}, cmt_vld_q};
    rptr_d    = rptr_q + {{A_WIDTH{1'b0}}, pop};
    rd_d      = rd_q;
    sig_d     = pop;
    if (acc) asm_d[fill_q[1:0]] = bus.i_data;
    // Assembler is cleared on every completion, so unfilled words are already zero.
    if (done) begin
      cmt_d.data  = asm_d;
      cmt_d.words = acc ? fill_q + 3'd1 : fill_q;
      asm_d       = '0;
      fill_d      = 3'd0;
    end else if (acc) begin
      fill_d = fill_q + 3'd1;
    end
    if (pop) rd_d = mem_q[rptr_q[A_WIDTH-1:0]];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      asm_q     <= '0;
      fill_q    <= 3'd0;
      cmt_vld_q <= 1'b0;
      cmt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_q      <= '0;
      sig_q     <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      fill_q    <= fill_d;
      cmt_vld_q <= cmt_vld_d;
      cmt_q     <= cmt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_q      <= rd_d;
      sig_q     <= sig_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (cmt_vld_q) mem_q[wptr_q[A_WIDTH-1:0]] <= cmt_q;
  end

  assign bus.o_data  = rd_q.data;
  assign bus.o_words = rd_q.words;
  assign bus.o_sig   = sig_q;
  assign bus.o_full  = full;
  assign bus.o_empty = empty;

`ifdef RAM_P2CC_ERR_EN
  logic err_q, err_d;

  always_comb err_d = err_q | (bus.i_en_w && full) | (bus.i_en_r && empty);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif
endmodule
